// File: rtl/encoder_speed_meter.sv
// Position, direction and step-period meter fed by a quadrature decoder.
// Define ENCODER_SPEED_FILTER_EN for a 4-tap moving average on o_period.
module encoder_speed_meter #(
   parameter int POS_WIDTH      = 16,
   parameter int PERIOD_WIDTH   = 20,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_step,
   input  logic                        i_polarity,
   input  logic                        i_clear_pos,
   output logic signed [POS_WIDTH-1:0] o_position,
   output logic                        o_direction,
   output logic [PERIOD_WIDTH-1:0]     o_period,
   output logic                        o_period_valid,
   output logic                        o_stalled
);

   localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};
   localparam logic [PERIOD_WIDTH:0]   TIMEOUT    =
      (PERIOD_WIDTH+1)'(TIMEOUT_CYCLES);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                    state;
   state_t                    state_nx;
   logic [PERIOD_WIDTH-1:0]   cnt;
   logic [PERIOD_WIDTH:0]     cnt_inc;
   logic [PERIOD_WIDTH-1:0]   period_raw;
   logic [PERIOD_WIDTH-1:0]   period_out;
   logic                      timeout;
   logic                      same_dir;
   logic                      enter_run;
   logic                      emit;
   logic                      reverse;
   logic                      stall_set;
   logic signed [POS_WIDTH-1:0] pos_delta;

   // cnt_inc carries one extra bit so the saturated counter never wraps
   always_comb begin
      cnt_inc    = {1'b0, cnt} + (PERIOD_WIDTH+1)'(1);
      period_raw = cnt_inc[PERIOD_WIDTH] ? PERIOD_MAX
                                         : cnt_inc[PERIOD_WIDTH-1:0];
      timeout    = (cnt_inc == TIMEOUT);
      same_dir   = (i_polarity == o_direction);
      pos_delta  = i_polarity ? POS_WIDTH'(1) : '1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (i_step) state_nx = RUN;
         RUN:  if (!i_step && timeout) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      enter_run = 1'b0;
      emit      = 1'b0;
      reverse   = 1'b0;
      stall_set = 1'b0;
      case (state)
         IDLE: enter_run = i_step;
         RUN: begin
            emit      = i_step && same_dir;
            reverse   = i_step && !same_dir;
            stall_set = !i_step && timeout;
         end
         default: ;
      endcase
   end

`ifdef ENCODER_SPEED_FILTER_EN
   // three older raw periods; the current raw period is the fourth tap
   logic [PERIOD_WIDTH-1:0] hist [3];
   logic                    hist_live;
   logic [PERIOD_WIDTH+1:0] filt_sum;

   always_comb begin
      filt_sum   = (PERIOD_WIDTH+2)'(period_raw)
                 + (PERIOD_WIDTH+2)'(hist[0])
                 + (PERIOD_WIDTH+2)'(hist[1])
                 + (PERIOD_WIDTH+2)'(hist[2]);
      period_out = hist_live ? PERIOD_WIDTH'(filt_sum >> 2) : period_raw;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || stall_set || reverse) begin
         hist_live <= 1'b0;
         hist[0]   <= '0;
         hist[1]   <= '0;
         hist[2]   <= '0;
      end else if (emit) begin
         hist_live <= 1'b1;
         hist[0]   <= period_raw;
         hist[1]   <= hist_live ? hist[0] : period_raw;
         hist[2]   <= hist_live ? hist[1] : period_raw;
      end
   end
`else
   always_comb begin
      period_out = period_raw;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt            <= '0;
         o_position     <= '0;
         o_direction    <= 1'b0;
         o_period       <= '0;
         o_period_valid <= 1'b0;
         o_stalled      <= 1'b1;
      end else begin
         if (i_step) begin
            cnt <= '0;
         end else if (!cnt_inc[PERIOD_WIDTH]) begin
            cnt <= cnt_inc[PERIOD_WIDTH-1:0];
         end
         if (i_clear_pos) begin
            o_position <= '0;
         end else if (i_step) begin
            o_position <= o_position + pos_delta;
         end
         if (i_step) begin
            o_direction <= i_polarity;
         end
         o_period_valid <= emit;
         if (emit) begin
            o_period <= period_out;
         end else if (stall_set) begin
            o_period <= '0;
         end
         if (enter_run) begin
            o_stalled <= 1'b0;
         end else if (stall_set) begin
            o_stalled <= 1'b1;
         end
      end
   end

endmodule
